ysyx_24090012_rf_write_arbiter: RTL
===================================

Name: ysyx_24090012_rf_write_arbiter

Overview:
- Shares the single register-file write port between two writeback sources: EXU (ALU/CSR/jump results) and LSU (load results).
- Tracks in-flight destination registers in a per-register scoreboard so IDU can stall on RAW hazards.
- Sits between EXU/LSU and the register file write interface.
- The register file accepts one write per handshake, with ready asserted while it is idle.

Parameters:
DATA_WIDTH, 32, write data width
NREG, 16, number of architectural registers (RV32E; x0 hardwired zero)
CNT_WIDTH, 2, width of the per-register in-flight counter

Ports:
clock  in  1  single clock, all state on posedge
reset  in  1  asynchronous, active-low reset
iss_valid  in  1  IDU dispatches an instruction that will write iss_rd
iss_rd  in  4  destination register of the dispatched instruction
rs1  in  4  IDU source register 1 query
rs2  in  4  IDU source register 2 query
stall  out  1  RAW hazard: rs1 or rs2 has a pending write
sb_overflow  out  1  sticky: a counter increment saturated
exu_valid  in  1  EXU write request
exu_ready  out  1  EXU request accepted this cycle
exu_rd  in  4  EXU destination
exu_data  in  DATA_WIDTH  EXU result
lsu_valid  in  1  LSU write request
lsu_ready  out  1  LSU request accepted this cycle
lsu_rd  in  4  LSU destination
lsu_data  in  DATA_WIDTH  LSU result
wr_valid  out  1  write request to the register file
wr_ready  in  1  register file ready (idle)
wr_addr  out  4  write address
wr_data  out  DATA_WIDTH  write data

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_valid=0, wr_addr=0, wr_data=0, sb_overflow=0.
  - All counters=0; round-robin pointer=EXU (EXU wins the first tie).
  - Reset mid-transfer discards the output register and all scoreboard state.
- Output stage: one register holding {wr_addr, wr_data}, flagged by wr_valid.
  - slot_free = !wr_valid || wr_ready.
- Arbitration, only when slot_free:
  - Only one requester valid: grant it.
  - Both valid: grant the pointer side; pointer then flips to the other side.
  - Pointer changes only on a contested grant.
- Readiness:
  - exu_ready = slot_free && exu granted; lsu_ready likewise. Combinational from valids, pointer, wr_valid, wr_ready.
  - Never more than one ready per cycle.
- Latency: granted request appears on wr_valid/wr_addr/wr_data on the next cycle.
- Back-to-back operation:
  - Output held stable while wr_valid && !wr_ready.
  - Once consumed, a new grant loads in the same cycle, giving a write every cycle when the register file is always ready.
- Requests with rd=0:
  - Handshake completes normally.
  - Nothing is loaded into the output register; wr_valid goes (or stays) 0 unless the held entry is still stalled.
- Scoreboard, counter cnt[r] for r=1..NREG-1 (cnt[0] is always 0):
  - inc when iss_valid && iss_rd==r.
  - dec when wr_valid && wr_ready && wr_addr==r.
  - inc and dec on the same register in the same cycle: counter unchanged.
  - inc at max (3): counter saturates and sb_overflow sets (sticky until reset).
  - dec at 0: counter is held at 0 (no underflow).
- stall = (rs1!=0 && cnt[rs1]!=0) || (rs2!=0 && cnt[rs2]!=0).
  - Combinational, evaluated from pre-update counters.
  - A write retiring this cycle does not clear stall until the next cycle; this matches the register file updating one cycle after its handshake.
- Width rules:
  - Only the low 4 bits of addresses are used.
  - Data passes through unmodified.

Test Plan:
- Reset release, no requests:
  - Required: wr_valid=0, stall=0, exu_ready=lsu_ready=0, sb_overflow=0.
- EXU rd=5 data=0x12345678, wr_ready=1:
  - Required: exu_ready=1 in cycle 0.
  - Required: wr_valid=1, wr_addr=5, wr_data=0x12345678 in cycle 1.
  - Required: wr_valid=0 in cycle 2.
- Both sources valid every cycle (EXU rd=1 0xA, LSU rd=2 0xB), wr_ready=1:
  - Required: grants alternate EXU, LSU, EXU…, with one write per cycle.
- wr_ready=0 for 3 cycles with an entry held:
  - Required: wr_addr/wr_data stable; exu_ready=lsu_ready=0.
  - Required: the next grant occurs in the cycle wr_ready returns to 1.
- iss_valid rd=7 twice, then rs1=7:
  - Required: stall=1.
  - After the first write to x7 retires: stall still 1.
  - After the second retires: stall=0 on the following cycle.
  - Issue of rd=7 coinciding with a retire of x7: count unchanged.
- Issue x3 four times without retiring:
  - Required: sb_overflow=1.
- EXU rd=0 request:
  - Required: handshake completes, no wr_valid, scoreboard unchanged.

Source files
------------

// File: rtl/ysyx_24090012_rf_write_arbiter.sv
// rtl/ysyx_24090012_rf_write_arbiter.sv - EXU/LSU register-file write arbiter with RAW scoreboard
module ysyx_24090012_rf_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NREG       = 16,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  iss_valid,
  input  logic [3:0]            iss_rd,
  input  logic [3:0]            rs1,
  input  logic [3:0]            rs2,
  output logic                  stall,
  output logic                  sb_overflow,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [3:0]            exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [3:0]            lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [3:0]            wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  localparam int AW = 4;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic                  wr_valid_q, wr_valid_d;
  logic [AW-1:0]         wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  ptr_q, ptr_d;
  logic                  ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]  cnt_q [NREG];
  logic [CNT_WIDTH-1:0]  cnt_d [NREG];

  logic slot_free, grant_exu, grant_lsu, retire;

  // ptr_q = 0 favours EXU on a tie, 1 favours LSU
  always_comb begin
    slot_free  = !wr_valid_q || wr_ready;
    grant_exu  = slot_free && exu_valid && (!lsu_valid || !ptr_q);
    grant_lsu  = slot_free && lsu_valid && (!exu_valid || ptr_q);
    retire     = wr_valid_q && wr_ready;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    ptr_d      = (slot_free && exu_valid && lsu_valid) ? !ptr_q : ptr_q;
    if (slot_free) begin
      wr_valid_d = 1'b0;
      if (grant_exu && exu_rd != '0) begin
        wr_valid_d = 1'b1;
        wr_addr_d  = exu_rd;
        wr_data_d  = exu_data;
      end else if (grant_lsu && lsu_rd != '0) begin
        wr_valid_d = 1'b1;
        wr_addr_d  = lsu_rd;
        wr_data_d  = lsu_data;
      end
    end
  end

  // An issue and a retire to the same register in one cycle cancel out
  always_comb begin
    ovf_d    = ovf_q;
    cnt_d[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (iss_valid && iss_rd == AW'(r) && !(retire && wr_addr_q == AW'(r))) begin
        if (cnt_q[r] == CNT_MAX) ovf_d = 1'b1;
        else                     cnt_d[r] = cnt_q[r] + CNT_WIDTH'(1);
      end else if (retire && wr_addr_q == AW'(r) && !(iss_valid && iss_rd == AW'(r))) begin
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      ptr_q      <= 1'b0;
      ovf_q      <= 1'b0;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      ptr_q      <= ptr_d;
      ovf_q      <= ovf_d;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  assign stall       = (rs1 != '0 && cnt_q[rs1] != '0) || (rs2 != '0 && cnt_q[rs2] != '0);
  assign sb_overflow = ovf_q;
  assign exu_ready   = grant_exu;
  assign lsu_ready   = grant_lsu;
  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;

endmodule
